// File: rtl/dot_product_sequencer_if.sv
// dot_product_sequencer_if: command, operand stream, MAC and result signals of the dot-product sequencer.
interface dot_product_sequencer_if #(
   parameter int A_DATA_WIDTH   = 32,
   parameter int B_DATA_WIDTH   = 32,
   parameter int RES_DATA_WIDTH = 64,
   parameter int LEN_WIDTH      = 16
);
   logic                      start;
   logic [LEN_WIDTH-1:0]      len;
   logic                      busy;
   logic                      in_valid;
   logic                      in_ready;
   logic [A_DATA_WIDTH-1:0]   in_a;
   logic [B_DATA_WIDTH-1:0]   in_b;
   logic [A_DATA_WIDTH-1:0]   mac_a;
   logic [B_DATA_WIDTH-1:0]   mac_b;
   logic [RES_DATA_WIDTH-1:0] mac_sum;
   logic [RES_DATA_WIDTH-1:0] mac_res;
   logic                      out_valid;
   logic                      out_ready;
   logic [RES_DATA_WIDTH-1:0] out_data;

   modport slave (
      input  start, len, in_valid, in_a, in_b, mac_res, out_ready,
      output busy, in_ready, mac_a, mac_b, mac_sum, out_valid, out_data
   );

   modport master (
      output start, len, in_valid, in_a, in_b, mac_res, out_ready,
      input  busy, in_ready, mac_a, mac_b, mac_sum, out_valid, out_data
   );
endinterface

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: streams operand pairs through an external MAC and returns the accumulated dot product.
module dot_product_sequencer #(
   parameter int A_DATA_WIDTH   = 32,
   parameter int B_DATA_WIDTH   = 32,
   parameter int RES_DATA_WIDTH = 64,
   parameter int LEN_WIDTH      = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   dot_product_sequencer_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]                state;
   logic [RES_DATA_WIDTH-1:0] acc;
   logic [RES_DATA_WIDTH-1:0] res;
   logic [LEN_WIDTH-1:0]      remaining;

   assign bus.busy      = state != IDLE;
   assign bus.in_ready  = state == ACCUM;
   assign bus.out_valid = state == DONE;
   assign bus.out_data  = res;
   assign bus.mac_a     = bus.in_a;
   assign bus.mac_b     = bus.in_b;
   assign bus.mac_sum   = acc;

   // res is captured on entry to DONE so it stays put until the next result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         res       <= '0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               acc <= '0;
               if (bus.len != '0) begin
                  remaining <= bus.len;
                  state     <= ACCUM;
               end else begin
                  res   <= '0;
                  state <= DONE;
               end
            end
            ACCUM: if (bus.in_valid) begin
               acc       <= bus.mac_res;
               remaining <= remaining - 1'b1;
               if (remaining == LEN_WIDTH'(1)) begin
                  res   <= bus.mac_res;
                  state <= DONE;
               end
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer: directed vectors and corner-case sequences against a behavioural MAC.
module tb_dot_product_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   dot_product_sequencer_if #(.A_DATA_WIDTH(8), .B_DATA_WIDTH(8), .RES_DATA_WIDTH(32), .LEN_WIDTH(16)) bus ();
   dot_product_sequencer_if #(.A_DATA_WIDTH(8), .B_DATA_WIDTH(8), .RES_DATA_WIDTH(16), .LEN_WIDTH(16)) bus16 ();

   dot_product_sequencer #(.A_DATA_WIDTH(8), .B_DATA_WIDTH(8), .RES_DATA_WIDTH(32), .LEN_WIDTH(16))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   dot_product_sequencer #(.A_DATA_WIDTH(8), .B_DATA_WIDTH(8), .RES_DATA_WIDTH(16), .LEN_WIDTH(16))
      dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

   assign bus.mac_res   = bus.mac_sum + 32'(bus.mac_a) * 32'(bus.mac_b);
   assign bus16.mac_res = 16'(bus16.mac_sum + 32'(bus16.mac_a) * 32'(bus16.mac_b));

   typedef struct {
      int              len;
      logic [3:0][7:0] a;
      logic [3:0][7:0] b;
      logic [31:0]     exp;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run(input int len, input logic [3:0][7:0] a, input logic [3:0][7:0] b, input logic [31:0] exp);
      @(negedge clk);
      bus.start = 1'b1;
      bus.len = 16'(len);
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_start", 32'(bus.busy), 1);
      for (int i = 0; i < len; i++) begin
         bus.in_valid = 1'b1;
         bus.in_a = a[i];
         bus.in_b = b[i];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("out_valid_after_last", 32'(bus.out_valid), 1);
      chk("out_data", bus.out_data, exp);
      chk("in_ready_in_done", 32'(bus.in_ready), 0);
      @(negedge clk);
      chk("out_valid_drop", 32'(bus.out_valid), 0);
      chk("busy_drop", 32'(bus.busy), 0);
   endtask

   task automatic beat(input logic [7:0] a, input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in_a = a;
      bus.in_b = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{3, {8'd0, 8'd3, 8'd2, 8'd1}, {8'd0, 8'd6, 8'd5, 8'd4}, 32'd32};
      vecs[1] = '{0, 32'd0, 32'd0, 32'd0};
      vecs[2] = '{1, {8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd255}, 32'd65025};
      vecs[3] = '{4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, 32'd30};
      vecs[4] = '{4, {4{8'd255}}, {4{8'd255}}, 32'd260100};
      vecs[5] = '{2, {8'd0, 8'd0, 8'd7, 8'd10}, {8'd0, 8'd0, 8'd3, 8'd10}, 32'd121};
      bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
      bus16.start = 1'b0; bus16.len = '0; bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.out_ready = 1'b1;
      #12;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", bus.out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) run(vecs[v].len, vecs[v].a, vecs[v].b, vecs[v].exp);

      // gaps on the input stream and back-pressure on the result
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.len = 16'd2;
      @(negedge clk);
      bus.start = 1'b0;
      beat(8'd10, 8'd10);
      for (int i = 0; i < 3; i++) begin
         chk("gap_in_ready", 32'(bus.in_ready), 1);
         chk("gap_out_valid", 32'(bus.out_valid), 0);
         @(negedge clk);
      end
      beat(8'd7, 8'd3);
      for (int i = 0; i < 4; i++) begin
         chk("stall_out_valid", 32'(bus.out_valid), 1);
         chk("stall_out_data", bus.out_data, 121);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_valid", 32'(bus.out_valid), 0);
      chk("stall_retain_data", bus.out_data, 121);

      // start while busy is ignored
      bus.start = 1'b1; bus.len = 16'd4;
      @(negedge clk);
      bus.start = 1'b0;
      beat(8'd1, 8'd2);
      bus.start = 1'b1; bus.len = 16'd1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("ign_busy", 32'(bus.busy), 1);
      beat(8'd3, 8'd4);
      chk("ign_not_done2", 32'(bus.out_valid), 0);
      beat(8'd5, 8'd6);
      chk("ign_not_done3", 32'(bus.out_valid), 0);
      beat(8'd7, 8'd8);
      chk("ign_done", 32'(bus.out_valid), 1);
      chk("ign_data", bus.out_data, 100);
      @(negedge clk);

      // start in the DONE completion cycle is ignored
      bus.start = 1'b1; bus.len = 16'd1;
      @(negedge clk);
      bus.start = 1'b0;
      beat(8'd2, 8'd3);
      chk("dstart_valid", 32'(bus.out_valid), 1);
      bus.start = 1'b1; bus.len = 16'd1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("dstart_ignored", 32'(bus.busy), 0);

      // asynchronous reset mid-vector
      bus.start = 1'b1; bus.len = 16'd5;
      @(negedge clk);
      bus.start = 1'b0;
      beat(8'd9, 8'd9);
      beat(8'd9, 8'd9);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_in_ready", 32'(bus.in_ready), 0);
      chk("arst_out_valid", 32'(bus.out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(1, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd3}, 32'd9);

      // 16-bit accumulator wraps
      @(negedge clk);
      bus16.start = 1'b1; bus16.len = 16'd2;
      @(negedge clk);
      bus16.start = 1'b0;
      bus16.in_valid = 1'b1; bus16.in_a = 8'd255; bus16.in_b = 8'd255;
      @(negedge clk);
      @(negedge clk);
      bus16.in_valid = 1'b0;
      chk("wrap_valid", 32'(bus16.out_valid), 1);
      chk("wrap_data", 32'(bus16.out_data), 64514);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
